// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl
//   Sequencing controller for a bank of WIDTH toggle flip-flops forming an
//   up/down counter. A run is launched from IDLE with start, counts toward a
//   terminal value (limit when counting up, 0 when counting down), may be
//   paused or aborted, and signals completion with a one-cycle done pulse.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   launch a run (sampled in IDLE only)
//   dir    in   0 = up, 1 = down (captured with start)
//   limit  in   terminal bound (captured with start)
//   pause  in   hold count and force t_vec to 0 while in RUN
//   abort  in   return to IDLE from RUN/DONE without a done pulse
//   t_vec  out  per-bit toggle enables for this cycle
//   count  out  current bank state
//   busy   out  high in RUN and DONE
//   done   out  one-cycle completion pulse
module tff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lim_q,   lim_d;
    logic             dir_q,   dir_d;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] count_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            lim_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
        end
    end

    // Toggle chain: bit i flips when every lower bit is 1 (up) or 0 (down),
    // which is exactly the carry/borrow pattern of +1 / -1.
    always_comb begin
        logic chain;
        t_vec = '0;
        chain = 1'b1;
        if (state_q == RUN && !pause) begin
            for (int i = 0; i < WIDTH; i++) begin
                t_vec[i] = chain;
                chain    = chain & (dir_q ? ~count_q[i] : count_q[i]);
            end
        end
    end

    assign target    = dir_q ? '0 : lim_q;
    assign count_nxt = count_q ^ t_vec;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lim_d   = lim_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lim_d   = limit;
                    dir_d   = dir;
                    count_d = dir ? limit : '0;
                    // A zero bound has nothing to count in either direction.
                    state_d = (limit == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // abort wins over both pause and terminal detection.
                if (abort) begin
                    state_d = IDLE;
                end else if (!pause) begin
                    count_d = count_nxt;
                    if (count_nxt == target) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign count = count_q;
    assign busy  = (state_q == RUN) || (state_q == DONE);
    // An abort landing on the DONE cycle suppresses the pulse.
    assign done  = (state_q == DONE) && !abort;

endmodule

// File: tb/tb_tff_count_ctrl.sv
module tb_tff_count_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, dir, pause, abort;
    logic [W-1:0] limit;
    logic [W-1:0] t_vec, count;
    logic         busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    tff_count_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .limit(limit),
        .pause(pause), .abort(abort), .t_vec(t_vec), .count(count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a run is "count by +/-1 until the target is hit".
    // m_mode: 0 idle, 1 counting, 2 finished (pulse cycle).
    int           m_mode;
    logic [W-1:0] m_cnt, m_lim;
    logic         m_dir;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_cnt = '0; m_lim = '0; m_dir = 1'b0;
        end else begin
            case (m_mode)
                0: if (start) begin
                    m_lim  = limit;
                    m_dir  = dir;
                    m_cnt  = dir ? limit : '0;
                    m_mode = (limit == 0) ? 2 : 1;
                end
                1: if (abort) m_mode = 0;
                   else if (!pause) begin
                       m_cnt = m_dir ? W'(m_cnt - 1) : W'(m_cnt + 1);
                       if (m_cnt == (m_dir ? W'(0) : m_lim)) m_mode = 2;
                   end
                default: m_mode = 0;
            endcase
        end
    end

    // Expected toggle pattern is simply the bits that differ between the
    // current value and the next value in the count direction.
    always @(negedge clk) begin
        logic [W-1:0] nx, et;
        nx = m_dir ? W'(m_cnt - 1) : W'(m_cnt + 1);
        et = (m_mode == 1 && !pause) ? (m_cnt ^ nx) : '0;
        chk("mdl_count", int'(count), int'(m_cnt));
        chk("mdl_t_vec", int'(t_vec), int'(et));
        chk("mdl_busy",  int'(busy),  int'(m_mode != 0));
        chk("mdl_done",  int'(done),  int'(m_mode == 2 && !abort));
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic neg();  @(negedge clk); endtask
    task automatic launch(input logic d, input int l);
        start = 1'b1; dir = d; limit = W'(l);
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int up_t[5];
        int dn_t[3];
        up_t = '{1, 3, 1, 7, 1};
        dn_t = '{1, 3, 1};
        rst = 1'b1; start = 0; dir = 0; pause = 0; abort = 0; limit = '0;
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        chk("rst_t_vec", int'(t_vec), 0);
        step(); step();
        rst = 1'b0;
        step();

        // Up run 0..5
        launch(1'b0, 5);
        for (int k = 0; k < 5; k++) begin
            neg(); chk("up_count", int'(count), k); chk("up_t", int'(t_vec), up_t[k]);
            step();
        end
        neg(); chk("up_done", int'(done), 1); chk("up_final", int'(count), 5);
        step();
        neg(); chk("up_busy_after", int'(busy), 0); chk("up_done_after", int'(done), 0);
        step();

        // Down run 3..0
        launch(1'b1, 3);
        for (int k = 0; k < 3; k++) begin
            neg(); chk("dn_count", int'(count), 3 - k); chk("dn_t", int'(t_vec), dn_t[k]);
            step();
        end
        neg(); chk("dn_done", int'(done), 1); chk("dn_final", int'(count), 0);
        step();

        // Pause for three cycles at count 2
        launch(1'b0, 4);
        neg(); step(); neg(); step(); neg();
        chk("ps_pre", int'(count), 2);
        #1 pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); neg();
            chk("ps_hold", int'(count), 2); chk("ps_t", int'(t_vec), 0); chk("ps_busy", int'(busy), 1);
        end
        #1 pause = 1'b0;
        step(); neg(); chk("ps_c3", int'(count), 3); chk("ps_nodone", int'(done), 0);
        step(); neg(); chk("ps_done", int'(done), 1); chk("ps_c4", int'(count), 4);
        step(); neg(); chk("ps_single", int'(done), 0);
        step();

        // Zero limit
        launch(1'b0, 0);
        neg(); chk("z_done", int'(done), 1); chk("z_count", int'(count), 0); chk("z_t", int'(t_vec), 0);
        step(); neg(); chk("z_busy", int'(busy), 0);
        step();

        // Start while busy is ignored
        launch(1'b0, 5);
        neg(); step(); neg(); step(); neg();
        #1 start = 1'b1; dir = 1'b1; limit = 4'd9;
        step(); start = 1'b0;
        neg(); chk("ig_c3", int'(count), 3);
        step(); neg(); chk("ig_c4", int'(count), 4);
        step(); neg(); chk("ig_done", int'(done), 1); chk("ig_c5", int'(count), 5);
        step();

        // Full range, no wrap
        launch(1'b0, 15);
        for (int k = 0; k < 15; k++) begin
            neg(); chk("fr_count", int'(count), k);
            if (k == 7) chk("fr_t7", int'(t_vec), 15);
            step();
        end
        neg(); chk("fr_done", int'(done), 1); chk("fr_final", int'(count), 15);
        step();

        // Abort at count 2
        launch(1'b0, 6);
        neg(); step(); neg(); step(); neg();
        #1 abort = 1'b1;
        step(); abort = 1'b0;
        neg(); chk("ab_busy", int'(busy), 0); chk("ab_count", int'(count), 2); chk("ab_done", int'(done), 0);
        step(); neg(); chk("ab_idle_done", int'(done), 0);
        step();

        // Async reset mid-run
        launch(1'b0, 9);
        neg(); step(); neg(); step();
        rst = 1'b1; #1;
        chk("ar_count", int'(count), 0); chk("ar_busy", int'(busy), 0); chk("ar_t", int'(t_vec), 0);
        #1 rst = 1'b0;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            start = ($urandom_range(0, 3) == 0);
            dir   = $urandom_range(0, 1);
            limit = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
            pause = ($urandom_range(0, 4) == 0);
            abort = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1; #1;
                chk("rr_count", int'(count), 0); chk("rr_busy", int'(busy), 0);
                #1 rst = 1'b0;
            end
        end
        step();
        start = 0; pause = 0; abort = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
